// File: rtl/codec_serializer.sv
// I2S-style mono DAC serializer: bclk/lrclk/new_frame timing, sample duplicated into both slots; CODEC_SER_UNDERRUN_EN enables underrun counting.
// Latency: sample captured at new_frame is shifted out MSB-first during the following frame, one bclk after each slot start.
// Backpressure: none; producer is paced by new_frame, a missing sample resends the last held value.
module codec_serializer #(
    parameter int CLK_DIV      = 4,
    parameter int SLOT_BITS    = 32,
    parameter int SAMPLE_WIDTH = 16
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [SAMPLE_WIDTH-1:0] sample_in,
    input  logic                    sample_strobe,
    input  logic                    mute,
    output logic                    new_frame,
    output logic                    bclk,
    output logic                    lrclk,
    output logic                    sdata,
    output logic [7:0]              underrun_count
);

    localparam int BW = $clog2(2 * SLOT_BITS);
    localparam int DW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [DW-1:0] DIV_LAST   = DW'(CLK_DIV - 1);
    localparam logic [BW-1:0] LAST_BIT   = BW'(2 * SLOT_BITS - 1);
    localparam logic [BW-1:0] SLOT_START = BW'(SLOT_BITS);

    logic [DW-1:0]           div_cnt;
    logic [BW-1:0]           bit_cnt;
    logic [SAMPLE_WIDTH-1:0] held;
    logic                    mute_latched;

    logic                    fe;
    logic [BW-1:0]           next_bit;
    logic [BW-1:0]           slot_k;
    logic                    data_bit;

    always_comb begin
        fe       = (div_cnt == DIV_LAST) && bclk;
        next_bit = (bit_cnt == LAST_BIT) ? '0 : bit_cnt + 1'b1;
        slot_k   = (next_bit >= SLOT_START) ? next_bit - SLOT_START : next_bit;
        data_bit = 1'b0;
        // k = 1..SAMPLE_WIDTH carries held MSB-first; k = 0 is the one-bclk I2S delay.
        for (int i = 0; i < SAMPLE_WIDTH; i++) begin
            if (slot_k == BW'(SAMPLE_WIDTH - i)) begin
                data_bit = held[i];
            end
        end
        if (mute_latched) begin
            data_bit = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            div_cnt      <= '0;
            bclk         <= 1'b0;
            bit_cnt      <= '0;
            lrclk        <= 1'b0;
            sdata        <= 1'b0;
            new_frame    <= 1'b0;
            held         <= '0;
            mute_latched <= 1'b0;
        end else begin
            new_frame <= 1'b0;
            if (div_cnt == DIV_LAST) begin
                div_cnt <= '0;
                bclk    <= ~bclk;
            end else begin
                div_cnt <= div_cnt + 1'b1;
            end
            if (fe) begin
                bit_cnt <= next_bit;
                lrclk   <= (next_bit >= SLOT_START);
                sdata   <= data_bit;
                // Mute only takes effect at slot boundaries so a slot is never cut short.
                if (slot_k == '0) begin
                    mute_latched <= mute;
                end
                if (next_bit == '0) begin
                    new_frame <= 1'b1;
                    held      <= sample_in;
                end
            end
        end
    end

`ifdef CODEC_SER_UNDERRUN_EN
    logic       strobe_seen;
    logic       primed;
    logic [7:0] underrun_q;

    // A strobe in the new_frame cycle itself still counts toward the frame being closed.
    always_ff @(posedge clk) begin
        if (reset) begin
            strobe_seen <= 1'b0;
            primed      <= 1'b0;
            underrun_q  <= '0;
        end else if (new_frame) begin
            if (primed && !strobe_seen && !sample_strobe && (underrun_q != 8'hFF)) begin
                underrun_q <= underrun_q + 1'b1;
            end
            strobe_seen <= 1'b0;
            primed      <= 1'b1;
        end else if (sample_strobe) begin
            strobe_seen <= 1'b1;
        end
    end

    assign underrun_count = underrun_q;
`else
    logic unused_strobe;
    assign unused_strobe  = sample_strobe;
    assign underrun_count = '0;
`endif

endmodule

// File: tb/tb_codec_serializer.sv
// Directed bench for codec_serializer: frame timing, slot data, mute, mid-frame reset, underrun counter.
// Expected slot words are {0, sample, zeros} built here from the sample under test.
module tb_codec_serializer;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        strobe = 1'b0;
    logic        mute = 1'b0;
    logic [15:0] sample_in = 16'h0000;
    logic        new_frame, bclk, lrclk, sdata;
    logic [7:0]  underrun_count;

    int vectors = 0;
    int miscompares = 0;
    int cyc = 0;
    int pulses = 0;
    int last_nf = -1;

    codec_serializer #(.CLK_DIV(4), .SLOT_BITS(32), .SAMPLE_WIDTH(16)) u_dut (
        .clk            (clk),
        .reset          (reset),
        .sample_in      (sample_in),
        .sample_strobe  (strobe),
        .mute           (mute),
        .new_frame      (new_frame),
        .bclk           (bclk),
        .lrclk          (lrclk),
        .sdata          (sdata),
        .underrun_count (underrun_count)
    );

`ifdef CODEC_SER_UNDERRUN_EN
    logic       f_strobe = 1'b0;
    logic       f_nf, f_bclk, f_lrclk, f_sdata;
    logic [7:0] f_uc;

    codec_serializer #(.CLK_DIV(2), .SLOT_BITS(17), .SAMPLE_WIDTH(16)) u_fast (
        .clk            (clk),
        .reset          (reset),
        .sample_in      (sample_in),
        .sample_strobe  (f_strobe),
        .mute           (1'b0),
        .new_frame      (f_nf),
        .bclk           (f_bclk),
        .lrclk          (f_lrclk),
        .sdata          (f_sdata),
        .underrun_count (f_uc)
    );
`endif

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= reset ? 0 : cyc + 1;

    always @(negedge clk) begin
        if (reset) begin
            pulses  = 0;
            last_nf = -1;
        end else if (new_frame) begin
            pulses  = pulses + 1;
            last_nf = cyc;
        end
    end

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp)
        else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] slot_word(input logic [15:0] s);
        return {1'b0, s, 15'b0};
    endfunction

    // Samples sdata once per bclk period for one 32-bit slot; optionally drives mute at bit set_k.
    task automatic read_slot(input int set_k, input logic set_val, output logic [31:0] w);
        w = '0;
        for (int k = 0; k < 32; k++) begin
            if (k == set_k) mute = set_val;
            w[31-k] = sdata;
            step(8);
        end
    endtask

`ifdef CODEC_SER_UNDERRUN_EN
    task automatic wait_fnf(input string tag);
        logic seen;
        seen = 1'b0;
        for (int i = 0; i < 200 && !seen; i++) begin
            step(1);
            if (f_nf) seen = 1'b1;
        end
        chk(tag, seen, 1);
    endtask
`endif

    initial begin
        logic [31:0] w;

        reset = 1'b1;
        step(3);
        chk("rst_outs", {bclk, lrclk, sdata, new_frame}, 0);
        chk("rst_underrun", underrun_count, 0);
        sample_in = 16'hA5C3;
        reset = 1'b0;

        step(3);   chk("bclk_c3", bclk, 0);
        step(1);   chk("bclk_c4", bclk, 1);
        step(4);   chk("bclk_c8", bclk, 0);
        step(4);   chk("bclk_c12", bclk, 1);
        step(243); chk("lrclk_c255", lrclk, 0);
        step(1);   chk("lrclk_c256", lrclk, 1);
        step(255); chk("nf_c511", new_frame, 0);
        chk("pulses_c511", pulses, 0);
        step(1);   chk("nf_c512", new_frame, 1);
        chk("lrclk_c512", lrclk, 0);
        step(1);   chk("nf_c513", new_frame, 0);
        step(3);

        read_slot(-1, 1'b0, w); chk("f2_left", w, slot_word(16'hA5C3));
        sample_in = 16'h1234;
        read_slot(-1, 1'b0, w); chk("f2_right", w, slot_word(16'hA5C3));
        chk("pulses_f3", pulses, 2);
        chk("last_nf_f3", last_nf, 1024);

        read_slot(10, 1'b1, w); chk("f3_left_mute_mid", w, slot_word(16'h1234));
        read_slot(10, 1'b0, w); chk("f3_right_muted", w, 0);
        read_slot(-1, 1'b0, w); chk("f4_left_resume", w, slot_word(16'h1234));
        sample_in = 16'hFFFF;
        read_slot(-1, 1'b0, w); chk("f4_right", w, slot_word(16'h1234));

        step(318);
        chk("pre_rst_bitcnt", u_dut.bit_cnt, 40);
        chk("pre_rst_lrclk", lrclk, 1);
        chk("pre_rst_sdata", sdata, 1);
        reset = 1'b1;
        step(1);
        chk("mid_rst_outs", {bclk, lrclk, sdata, new_frame}, 0);
        chk("mid_rst_bitcnt", u_dut.bit_cnt, 0);
        step(1);
        reset = 1'b0;

        step(4);
        chk("rst2_pulses_c4", pulses, 0);
        read_slot(-1, 1'b0, w); chk("rst2_f1_left", w, 0);
        read_slot(-1, 1'b0, w); chk("rst2_f1_right", w, 0);
        chk("rst2_pulses", pulses, 1);
        chk("rst2_last_nf", last_nf, 512);

`ifdef CODEC_SER_UNDERRUN_EN
        reset = 1'b1;
        step(2);
        reset = 1'b0;
        wait_fnf("fast_nf1");
        step(3); f_strobe = 1'b1; step(1); f_strobe = 1'b0;
        wait_fnf("fast_nf2");
        step(3); f_strobe = 1'b1; step(1); f_strobe = 1'b0;
        wait_fnf("fast_nf3");
        chk("uc_nf3", f_uc, 0);
        wait_fnf("fast_nf4");
        step(1);
        chk("uc_nf4", f_uc, 1);
        wait_fnf("fast_nf5");
        f_strobe = 1'b1; step(1); f_strobe = 1'b0;
        chk("uc_nf5_coincident", f_uc, 1);
        for (int i = 0; i < 253; i++) wait_fnf("fast_nf_run");
        step(1);
        chk("uc_254", f_uc, 254);
        for (int i = 0; i < 47; i++) wait_fnf("fast_nf_sat");
        step(1);
        chk("uc_sat", f_uc, 255);
`else
        strobe = 1'b1; step(1); strobe = 1'b0;
        step(600);
        chk("uc_tied_zero", underrun_count, 0);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/codec_serializer.md
Name: codec_serializer

Overview:
- Serial DAC-side end of the sample/new_frame handshake.
- Generates the audio frame timing: bit clock, LR clock and a one-cycle new_frame request.
- Captures the 16-bit sample held by the producer (music player / codec conditioner path) at each frame start.
- Shifts that sample MSB-first, I2S-style, into both left and right slots (mono duplicated).

Parameters:
- CLK_DIV, 4: clk cycles per bclk half-period; bclk period = 2*CLK_DIV clk cycles; legal values >= 2.
- SLOT_BITS, 32: bclk periods per channel slot; legal values >= 17.
- SAMPLE_WIDTH, 16: bits of sample data sent per slot.

Ports:
- clk  input  1  system clock.
- reset  input  1  synchronous, active-high reset.
- sample_in  input  SAMPLE_WIDTH  sample held by the producer, two's complement.
- sample_strobe  input  1  one-cycle pulse; producer delivered a new sample (monitor use only).
- mute  input  1  forces silent data, applied at slot boundaries.
- new_frame  output  1  one-cycle pulse at each frame start; requests the next sample.
- bclk  output  1  serial bit clock.
- lrclk  output  1  0 = left slot, 1 = right slot.
- sdata  output  1  serial data, changes only on bclk falling-edge events.
- underrun_count  output  8  saturating count of frames with no sample delivered.

Behaviour:
- Reset: div_cnt=0, bclk=0, bit_cnt=0, lrclk=0, sdata=0, new_frame=0, held sample=0, mute_latched=0, underrun_count=0, strobe_seen=0, primed=0.
- Reset mid-frame aborts the frame immediately; no partial-frame state survives.
- Divider:
  - div_cnt counts 0..CLK_DIV-1; the wrap cycle toggles bclk.
  - A wrap with bclk=1 is a falling event (fe); a wrap with bclk=0 is a rising event.
- Bit counter:
  - bit_cnt counts 0..2*SLOT_BITS-1 and advances on each fe.
  - Frame period = 2*SLOT_BITS*2*CLK_DIV clk cycles (512 with defaults).
  - lrclk is registered, updated on fe, = (next bit_cnt >= SLOT_BITS).
- Frame start:
  - On the fe where bit_cnt wraps 2*SLOT_BITS-1 -> 0, new_frame=1 for exactly that clk cycle.
  - In the same cycle: held <= sample_in and mute_latched <= mute.
  - The first frame start occurs after one full frame from reset.
  - Data latency: a sample is sent in the frame after the new_frame that captured it.
- Serial data, on fe, with k = next bit_cnt mod SLOT_BITS:
  - sdata <= held[SAMPLE_WIDTH-k] for 1 <= k <= SAMPLE_WIDTH (one-bclk I2S delay, MSB first).
  - sdata <= 0 for k=0 and for k > SAMPLE_WIDTH.
  - Left and right slots carry the identical held value.
- Mute:
  - mute is also re-latched at the right-slot start (k=0 with lrclk going 1).
  - While mute_latched=1, sdata is 0 for the whole slot.
  - Toggling mute mid-slot has no effect until the next slot boundary.
- sample_in changes between frame starts are ignored.
- No sample_strobe is required for data output; a missing sample resends the last held value.

Optional Feature:
- Macro CODEC_SER_UNDERRUN_EN.
- Defined:
  - sample_strobe sets strobe_seen.
  - At each new_frame cycle, if primed=1 and neither strobe_seen nor a same-cycle sample_strobe is present, underrun_count increments, saturating at 255.
  - Then strobe_seen is cleared and primed is set; a same-cycle strobe counts toward the closing frame.
  - The first frame after reset is never counted.
- Not defined: underrun_count is tied to 0 and sample_strobe is ignored.

Test Plan:
- Reset with defaults, hold 600 cycles -> bclk period 8 clk, lrclk toggles every 256 clk, first new_frame pulse at clk cycle 512 after reset release, then every 512 cycles, each 1 cycle wide.
- sample_in=16'hA5C3 stable across a frame start -> next frame left slot: sdata=0 at k=0, then bits 1010010111000011 at k=1..16, 0 at k=17..31; right slot identical.
- sample_in changes to 16'h1234 mid-frame -> current frame still sends the old value; 16'h1234 sent only after the next capture.
- mute=1 asserted mid-left-slot -> left slot finishes with data; right slot all zeros; mute=0 mid-right-slot -> data resumes at the next left slot.
- Reset asserted at bit_cnt=40 -> next cycle all outputs 0, bit_cnt=0; frame timing restarts from scratch.
- CODEC_SER_UNDERRUN_EN defined: strobe after each of frames 1-2, none after frame 3, strobe coincident with new_frame 5 -> underrun_count=1; 300 strobe-less frames -> saturates at 255.
